// File: rtl/iter_shift_unit.sv
// Multi-cycle shift execution unit: decodes opcode/ffield into SLL/SRL/SRA/ROL and
// shifts the captured operand by up to STEP bits per cycle, with start/busy/done handshake.
module iter_shift_unit #(
  parameter int          WIDTH     = 16,
  parameter int          STEP      = 1,
  parameter logic [3:0]  SH_OPCODE = 4'b0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [3:0]                 opcode,
  input  logic [3:0]                 ffield,
  input  logic [WIDTH-1:0]           operand,
  input  logic [$clog2(WIDTH)-1:0]   shamt,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           result,
  output logic [2:0]                 sh_op
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W+1)'(STEP);
  localparam logic [SHAMT_W:0] WIDTH_W = (SHAMT_W+1)'(WIDTH);

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [SHAMT_W-1:0] remaining_q, remaining_d;
  logic [2:0]         sh_op_q, sh_op_d;

  logic [2:0]         decodedOp;
  logic [SHAMT_W-1:0] stepAmt;
  logic [WIDTH-1:0]   shiftedWork;

  function automatic logic [WIDTH-1:0] doShift(input logic [2:0] op,
                                               input logic [WIDTH-1:0] v,
                                               input logic [SHAMT_W-1:0] n);
    logic [SHAMT_W:0] back;
    logic [WIDTH-1:0] r;
    back = WIDTH_W - {1'b0, n};
    case (op)
      OP_SLL:  r = v << n;
      OP_SRL:  r = v >> n;
      OP_SRA:  r = $signed(v) >>> n;
      OP_ROL:  r = (v << n) | (v >> back);
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    decodedOp = OP_NONE;
    if (opcode == SH_OPCODE) begin
      case (ffield)
        4'b0001: decodedOp = OP_SLL;
        4'b0010: decodedOp = OP_SRL;
        4'b0011: decodedOp = OP_SRA;
        4'b0100: decodedOp = OP_ROL;
        default: decodedOp = OP_NONE;
      endcase
    end
  end

  // A step of STEP bits never exceeds what is left; STEP==WIDTH always takes the remainder.
  always_comb begin
    stepAmt     = ({1'b0, remaining_q} >= STEP_W) ? STEP_W[SHAMT_W-1:0] : remaining_q;
    shiftedWork = doShift(sh_op_q, work_q, stepAmt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      work_q      <= '0;
      result_q    <= '0;
      remaining_q <= '0;
      sh_op_q     <= OP_NONE;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      result_q    <= result_d;
      remaining_q <= remaining_d;
      sh_op_q     <= sh_op_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    result_d    = result_q;
    remaining_d = remaining_q;
    sh_op_d     = sh_op_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sh_op_d = decodedOp;
          if (decodedOp == OP_NONE || shamt == '0) begin
            state_d  = S_DONE;
            result_d = operand;
          end else begin
            state_d     = S_SHIFT;
            work_d      = operand;
            remaining_d = shamt;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        work_d      = shiftedWork;
        remaining_d = remaining_q - stepAmt;
        if (remaining_q == stepAmt) begin
          state_d  = S_DONE;
          result_d = shiftedWork;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == S_SHIFT);
    done   = (state_q == S_DONE);
    result = result_q;
    sh_op  = sh_op_q;
  end

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed bench for iter_shift_unit: one instance with STEP=1 and one with STEP=4,
// hand-computed results, sh_op and start->done latencies.
module tb_iter_shift_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic [3:0]  opcode = '0;
  logic [3:0]  ffield = '0;
  logic [15:0] operand = '0;
  logic [3:0]  shamt = '0;

  logic        busy1, done1, busy4, done4;
  logic [15:0] result1, result4;
  logic [2:0]  shOp1, shOp4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iter_shift_unit #(.WIDTH(16), .STEP(1), .SH_OPCODE(4'b0000)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .opcode(opcode), .ffield(ffield),
    .operand(operand), .shamt(shamt), .busy(busy1), .done(done1),
    .result(result1), .sh_op(shOp1)
  );

  iter_shift_unit #(.WIDTH(16), .STEP(4), .SH_OPCODE(4'b0000)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .opcode(opcode), .ffield(ffield),
    .operand(operand), .shamt(shamt), .busy(busy4), .done(done4),
    .result(result4), .sh_op(shOp4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Issues one request on the chosen instance (1 or 4) and checks latency, result and sh_op.
  task automatic applyStimulus(input int sel, input logic [3:0] op, input logic [3:0] ff,
                               input logic [15:0] val, input logic [3:0] amt,
                               input logic [15:0] expRes, input logic [2:0] expOp,
                               input int expLat);
    int   lat;
    logic d, b;
    opcode  = op;
    ffield  = ff;
    operand = val;
    shamt   = amt;
    if (sel == 1) start1 = 1'b1; else start4 = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      start1 = 1'b0;
      start4 = 1'b0;
      lat++;
      d = (sel == 1) ? done1 : done4;
      b = (sel == 1) ? busy1 : busy4;
      if (!d && lat < 200) checkOutput("busy_while_shifting", 32'(b), 32'd1);
    end while (!d && lat < 200);
    checkOutput("done_seen", 32'(d), 32'd1);
    checkOutput("busy_with_done", 32'(b), 32'd0);
    checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("result", 32'((sel == 1) ? result1 : result4), 32'(expRes));
    checkOutput("sh_op", 32'((sel == 1) ? shOp1 : shOp4), 32'(expOp));
    @(negedge clk);
    checkOutput("done_one_cycle", 32'((sel == 1) ? done1 : done4), 32'd0);
    checkOutput("idle_not_busy", 32'((sel == 1) ? busy1 : busy4), 32'd0);
    checkOutput("result_held", 32'((sel == 1) ? result1 : result4), 32'(expRes));
  endtask

  initial begin
    int lat;
    int doneCount;

    #1;
    checkOutput("reset_busy", 32'(busy1), 32'd0);
    checkOutput("reset_done", 32'(done1), 32'd0);
    checkOutput("reset_result", 32'(result1), 32'd0);
    checkOutput("reset_sh_op", 32'(shOp1), 32'd0);
    checkOutput("reset_result4", 32'(result4), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(1, 4'b0000, 4'b0001, 16'h0001, 4'd4,  16'h0010, 3'b001, 5);
    applyStimulus(1, 4'b0000, 4'b0011, 16'h8000, 4'd15, 16'hFFFF, 3'b011, 16);
    applyStimulus(1, 4'b0000, 4'b0010, 16'h8000, 4'd15, 16'h0001, 3'b010, 16);
    applyStimulus(1, 4'b0000, 4'b0100, 16'h8001, 4'd1,  16'h0003, 3'b100, 2);
    applyStimulus(1, 4'b0001, 4'b0001, 16'h1234, 4'd3,  16'h1234, 3'b000, 1);
    applyStimulus(1, 4'b0000, 4'b0101, 16'h5A5A, 4'd2,  16'h5A5A, 3'b000, 1);
    applyStimulus(1, 4'b0000, 4'b1111, 16'hBEEF, 4'd9,  16'hBEEF, 3'b000, 1);
    applyStimulus(1, 4'b0000, 4'b0001, 16'hABCD, 4'd0,  16'hABCD, 3'b001, 1);

    applyStimulus(4, 4'b0000, 4'b0001, 16'h0001, 4'd7,  16'h0080, 3'b001, 3);
    applyStimulus(4, 4'b0000, 4'b0100, 16'h8001, 4'd5,  16'h0030, 3'b100, 3);
    applyStimulus(4, 4'b0000, 4'b0011, 16'hC000, 4'd14, 16'hFFFF, 3'b011, 5);
    applyStimulus(4, 4'b0000, 4'b0010, 16'hF000, 4'd15, 16'h0001, 3'b010, 5);

    // A start pulse with different inputs while shifting must not disturb the request.
    opcode = 4'b0000; ffield = 4'b0001; operand = 16'h0001; shamt = 4'd8;
    start1 = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      start1 = 1'b0;
      lat++;
      if (lat == 2) begin
        opcode = 4'b0000; ffield = 4'b0010; operand = 16'hFFFF; shamt = 4'd1;
        start1 = 1'b1;
      end
    end while (!done1 && lat < 200);
    checkOutput("ignore_latency", 32'(lat), 32'd9);
    checkOutput("ignore_result", 32'(result1), 32'h0100);
    checkOutput("ignore_sh_op", 32'(shOp1), 32'd1);
    @(negedge clk);

    // Reset in the middle of a shift aborts it with no trailing done pulse.
    opcode = 4'b0000; ffield = 4'b0011; operand = 16'h8000; shamt = 4'd15;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_reset_busy", 32'(busy1), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy1), 32'd0);
    checkOutput("abort_done", 32'(done1), 32'd0);
    checkOutput("abort_result", 32'(result1), 32'd0);
    checkOutput("abort_sh_op", 32'(shOp1), 32'd0);
    checkOutput("abort_result4", 32'(result4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done1 || busy1) doneCount++;
    end
    checkOutput("no_done_after_abort", 32'(doneCount), 32'd0);

    applyStimulus(1, 4'b0000, 4'b0001, 16'h0003, 4'd2, 16'h000C, 3'b001, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
